// File: rtl/geofence_xprod_arb.sv
// Round-robin arbiter (with bounded burst lock) sharing one pipelined cross-product engine
// between two geofence requesters. Optional grant statistics: define GEOFENCE_XPROD_STATS_EN.
module geofence_xprod_arb #(
  parameter int CW       = 10,
  parameter int PIPE     = 2,
  parameter int LOCK_MAX = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_lock,
  input  logic [6*CW-1:0]       req0_pts,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_lock,
  input  logic [6*CW-1:0]       req1_pts,
  output logic                  req1_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic signed [2*CW+2:0] rsp_val,
  output logic                  rsp_neg,
  output logic                  rsp_zero,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
);
  localparam int DW = CW + 1;
  localparam int PW = 2 * CW + 2;
  localparam int VW = 2 * CW + 3;
  localparam int RD = (PIPE == 1) ? 1 : PIPE - 1;

  logic       prio_q, prio_d;
  logic       lock_act_q, lock_act_d;
  logic       lock_own_q, lock_own_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       own_vld, lock_eff, gnt0, gnt1, xfer, xid, xlock, oth_vld;

  // A lock only binds while its owner keeps valid asserted.
  assign own_vld  = lock_own_q ? req1_valid : req0_valid;
  assign lock_eff = lock_act_q & own_vld;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_eff) begin
      gnt0 = ~lock_own_q;
      gnt1 = lock_own_q;
    end else if (req0_valid & req1_valid) begin
      gnt0 = ~prio_q;
      gnt1 = prio_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign xid        = gnt1;
  assign xlock      = gnt1 ? req1_lock : req0_lock;
  assign oth_vld    = gnt1 ? req0_valid : req1_valid;

  always_comb begin
    prio_d     = prio_q;
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    if (lock_act_q && !own_vld) begin
      lock_act_d = 1'b0;
      lock_own_d = 1'b0;
      lock_cnt_d = 4'd0;
    end
    if (xfer) begin
      prio_d = ~xid;
      if (!xlock) begin
        lock_act_d = 1'b0;
        lock_own_d = 1'b0;
        lock_cnt_d = 4'd0;
      end else begin
        lock_act_d = 1'b1;
        lock_own_d = xid;
        lock_cnt_d = (lock_eff ? lock_cnt_q : 4'd0) + {3'b000, oth_vld};
        // Forced release: the pointer already favours the waiting requester.
        if (oth_vld && (lock_cnt_d >= 4'(LOCK_MAX))) begin
          lock_act_d = 1'b0;
          lock_own_d = 1'b0;
          lock_cnt_d = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= 1'b0;
      lock_act_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= 4'd0;
    end else begin
      prio_q     <= prio_d;
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  function automatic logic signed [DW-1:0] dif(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic signed [PW-1:0] sx(input logic signed [DW-1:0] d);
    return {{(PW-DW){d[DW-1]}}, d};
  endfunction

  logic [6*CW-1:0]      sel_pts;
  logic signed [DW-1:0] dax, day, dbx, dby;

  assign sel_pts = gnt1 ? req1_pts : req0_pts;
  assign dax = dif(sel_pts[4*CW-1 -: CW], sel_pts[6*CW-1 -: CW]);
  assign day = dif(sel_pts[3*CW-1 -: CW], sel_pts[5*CW-1 -: CW]);
  assign dbx = dif(sel_pts[2*CW-1 -: CW], sel_pts[6*CW-1 -: CW]);
  assign dby = dif(sel_pts[CW-1:0],       sel_pts[5*CW-1 -: CW]);

  logic                 src_vld, src_id;
  logic signed [DW-1:0] src_dax, src_day, src_dbx, src_dby;

  generate
    if (PIPE == 1) begin : g_direct
      assign src_vld = xfer;
      assign src_id  = xid;
      assign src_dax = dax;
      assign src_day = day;
      assign src_dbx = dbx;
      assign src_dby = dby;
    end else begin : g_opreg
      logic                 op_vld_q, op_id_q;
      logic signed [DW-1:0] op_dax_q, op_day_q, op_dbx_q, op_dby_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          op_vld_q <= 1'b0;
          op_id_q  <= 1'b0;
          op_dax_q <= '0;
          op_day_q <= '0;
          op_dbx_q <= '0;
          op_dby_q <= '0;
        end else begin
          op_vld_q <= xfer;
          if (xfer) begin
            op_id_q  <= xid;
            op_dax_q <= dax;
            op_day_q <= day;
            op_dbx_q <= dbx;
            op_dby_q <= dby;
          end
        end
      end
      assign src_vld = op_vld_q;
      assign src_id  = op_id_q;
      assign src_dax = op_dax_q;
      assign src_day = op_day_q;
      assign src_dbx = op_dbx_q;
      assign src_dby = op_dby_q;
    end
  endgenerate

  logic signed [PW-1:0] prod_a, prod_b;
  logic signed [VW-1:0] src_val;

  assign prod_a  = sx(src_dax) * sx(src_dby);
  assign prod_b  = sx(src_dbx) * sx(src_day);
  assign src_val = {prod_a[PW-1], prod_a} - {prod_b[PW-1], prod_b};

  logic          res_vld_q  [RD];
  logic          res_id_q   [RD];
  logic [VW-1:0] res_val_q  [RD];
  logic          res_neg_q  [RD];
  logic          res_zero_q [RD];

  // Data stages load only behind a valid, so the output holds its last result across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RD; k++) begin
        res_vld_q[k]  <= 1'b0;
        res_id_q[k]   <= 1'b0;
        res_val_q[k]  <= '0;
        res_neg_q[k]  <= 1'b0;
        res_zero_q[k] <= 1'b0;
      end
    end else begin
      res_vld_q[0] <= src_vld;
      if (src_vld) begin
        res_id_q[0]   <= src_id;
        res_val_q[0]  <= src_val;
        res_neg_q[0]  <= src_val[VW-1];
        res_zero_q[0] <= (src_val == '0);
      end
      for (int k = 1; k < RD; k++) begin
        res_vld_q[k] <= res_vld_q[k-1];
        if (res_vld_q[k-1]) begin
          res_id_q[k]   <= res_id_q[k-1];
          res_val_q[k]  <= res_val_q[k-1];
          res_neg_q[k]  <= res_neg_q[k-1];
          res_zero_q[k] <= res_zero_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = res_vld_q[RD-1];
  assign rsp_id    = res_id_q[RD-1];
  assign rsp_val   = res_val_q[RD-1];
  assign rsp_neg   = res_neg_q[RD-1];
  assign rsp_zero  = res_zero_q[RD-1];

`ifdef GEOFENCE_XPROD_STATS_EN
  logic [15:0] gcnt0_q, gcnt1_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt0_q <= 16'd0;
      gcnt1_q <= 16'd0;
    end else begin
      if (gnt0 && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
      if (gnt1 && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
    end
  end
  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`else
  assign grant_cnt0 = 16'd0;
  assign grant_cnt1 = 16'd0;
`endif

endmodule
